// File: rtl/memory_control.sv
// memory_control: arbitrates cache instruction-fetch and data requests onto a
// single-ported RAM and returns wait/load responses to the requesters.
//
// Ports:
//   CLK, nRST                          clock (rising edge), async active-low reset
//   iREN, iaddr                        instruction read request
//   dREN, dWEN, daddr, dstore          data read/write request (write wins)
//   iwait/iload, dwait/dload           responses; wait=0 marks a valid load
//   ramREN, ramWEN, ramaddr, ramstore  RAM command
//   ramload, ramstate                  RAM read data and status
//   merror                             sticky flag: an access was aborted
module memory_control #(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        merror
);

    typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_e;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic       last_d_q, last_d_d;
    logic [7:0] cnt_q, cnt_d;
    logic       merror_q, merror_d;

    logic dreq, ireq, expire;
    assign dreq   = dREN | dWEN;
    assign ireq   = iREN;
    assign expire = (ramstate == RAM_ERROR) || (cnt_q == CNT_LAST);

    // Ties go to the side that did not own the last completed grant.
    function automatic state_e arb(input logic dp, input logic ip, input logic ld);
        if (dp && ip) return ld ? ISERVE : DSERVE;
        else if (dp)  return DSERVE;
        else if (ip)  return ISERVE;
        else          return IDLE;
    endfunction

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            cnt_q    <= 8'd0;
            merror_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            cnt_q    <= cnt_d;
            merror_q <= merror_d;
        end
    end

    assign merror = merror_q;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        cnt_d    = cnt_q;
        merror_d = merror_q;
        iwait    = 1'b1;
        iload    = 32'd0;
        dwait    = 1'b1;
        dload    = 32'd0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;

        case (state_q)
            IDLE: state_d = arb(dreq, ireq, last_d_q);

            DSERVE: begin
                if (!dreq) begin
                    // owner withdrew: drop the access silently
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (ramstate == RAM_ACCESS) begin
                        dwait    = 1'b0;
                        dload    = ramload;
                        last_d_d = 1'b1;
                        cnt_d    = 8'd0;
                        state_d  = arb(dreq, ireq, 1'b1);
                    end else if (expire) begin
                        dwait    = 1'b0;
                        dload    = ERRWORD;
                        merror_d = 1'b1;
                        last_d_d = 1'b1;
                        cnt_d    = 8'd0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                end
            end

            ISERVE: begin
                if (!ireq) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ramstate == RAM_ACCESS) begin
                        iwait    = 1'b0;
                        iload    = ramload;
                        last_d_d = 1'b0;
                        cnt_d    = 8'd0;
                        state_d  = arb(dreq, ireq, 1'b0);
                    end else if (expire) begin
                        iwait    = 1'b0;
                        iload    = ERRWORD;
                        merror_d = 1'b1;
                        last_d_d = 1'b0;
                        cnt_d    = 8'd0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_control.sv
module tb_memory_control;

    localparam logic [31:0] ERRW = 32'hBAD1BAD1;
    localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = 32'h0, daddr = 32'h0, dstore = 32'h0, ramload = 32'h0;
    logic [1:0]  ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN, merror;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int vecs = 0;
    int errs = 0;
    logic [31:0] iq[$];
    logic [31:0] dq[$];

    memory_control #(.TIMEOUT(4), .ERRWORD(ERRW)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .merror(merror)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every response pulse must match the oldest expected value.
    always @(negedge CLK) begin
        if (nRST) begin
            if (!dwait) begin
                if (dq.size() > 0) chk("dload", dload, dq.pop_front());
                else               chk("dwait_spurious", 32'(dwait), 32'd1);
            end else if (dload !== 32'd0) chk("dload_idle", dload, 32'd0);
            if (!iwait) begin
                if (iq.size() > 0) chk("iload", iload, iq.pop_front());
                else               chk("iwait_spurious", 32'(iwait), 32'd1);
            end else if (iload !== 32'd0) chk("iload_idle", iload, 32'd0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        errs++;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        // reset values
        #2;
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_ren", 32'({ramREN, ramWEN}), 32'd0);
        chk("rst_addr", ramaddr, 32'd0);
        chk("rst_merror", 32'(merror), 32'd0);
        cyc(); nRST = 1'b1;
        cyc();

        // single data write, ACCESS on 2nd serve cycle
        dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
        ramload = 32'h00001234;
        cyc();
        @(negedge CLK);
        chk("wr_wen", 32'(ramWEN), 32'd1);
        chk("wr_ren", 32'(ramREN), 32'd0);
        chk("wr_addr", ramaddr, 32'h100);
        chk("wr_store", ramstore, 32'hDEADBEEF);
        chk("wr_dwait1", 32'(dwait), 32'd1);
        cyc(); ramstate = ACCESS; dq.push_back(32'h00001234);
        cyc(); dWEN = 1'b0; ramstate = FREE;
        cyc(); cyc();

        // timeout: 4th serve cycle aborts
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY; iq.push_back(ERRW);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge CLK);
            chk("to_iwait", 32'(iwait), 32'd1);
            chk("to_addr", ramaddr, 32'h40);
        end
        cyc();
        @(negedge CLK);
        chk("to_pulse", 32'(iwait), 32'd0);
        cyc(); iREN = 1'b0;
        @(negedge CLK);
        chk("to_idle_ren", 32'(ramREN), 32'd0);
        chk("to_merror", 32'(merror), 32'd1);
        cyc();

        // RAM ERROR on first data serve cycle
        dREN = 1'b1; daddr = 32'h200; ramstate = ERROR; dq.push_back(ERRW);
        cyc();
        @(negedge CLK);
        chk("err_pulse", 32'(dwait), 32'd0);
        cyc(); dREN = 1'b0; ramstate = FREE;
        cyc();
        chk("err_merror", 32'(merror), 32'd1);

        // reset clears sticky error and last_d
        nRST = 1'b0; #1;
        chk("rst2_merror", 32'(merror), 32'd0);
        cyc(); nRST = 1'b1;
        cyc();

        // contention: D, I, D, I
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000; ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            cyc();
            ramload = 32'hA000 + 32'(k);
            if (k % 2 == 0) dq.push_back(32'hA000 + 32'(k));
            else            iq.push_back(32'hA000 + 32'(k));
            @(negedge CLK);
            chk("ct_addr", ramaddr, (k % 2 == 0) ? 32'h2000 : 32'h1000);
            chk("ct_ren", 32'(ramREN), 32'd1);
        end
        cyc(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
        cyc(); cyc();

        // withdrawal during DSERVE
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        cyc();
        @(negedge CLK);
        chk("wd_ren", 32'(ramREN), 32'd1);
        cyc(); dREN = 1'b0; #1;
        chk("wd_ren_fall", 32'(ramREN), 32'd0);
        chk("wd_dwait", 32'(dwait), 32'd1);
        cyc(); dREN = 1'b1;  // now in IDLE: no enable this cycle
        #1;
        chk("wd_idle", 32'(ramREN), 32'd0);
        dREN = 1'b0;
        cyc(); cyc();

        // async reset mid-ISERVE
        iREN = 1'b1; iaddr = 32'h500; ramstate = BUSY;
        cyc();
        @(negedge CLK);
        chk("ar_ren", 32'(ramREN), 32'd1);
        #2; nRST = 1'b0; #1;
        chk("ar_ren0", 32'(ramREN), 32'd0);
        chk("ar_addr0", ramaddr, 32'd0);
        chk("ar_iwait", 32'(iwait), 32'd1);
        iREN = 1'b0; ramstate = ACCESS;
        cyc(); nRST = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        ramstate = FREE;

        chk("iq_drained", 32'(iq.size()), 32'd0);
        chk("dq_drained", 32'(dq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
